wb_write_ctrl: RTL and testbench
================================

# wb_write_ctrl

Writeback controller driving the register file write port (`A3`, `WriteData`, `WE`) of the RISC-V microarchitecture. It arbitrates between the ALU result path and the load result path with a valid/ready handshake and registers one write per cycle. It keeps a pending-destination scoreboard that the hazard logic reads. Writes to x0 are suppressed, so the register file never needs to protect x0 itself.

## Interface
Parameters:
- `STARVE_MAX`, 3: number of consecutive lost arbitrations after which the ALU gets priority for one grant.

Ports:
- `Clk`  in  1  clock. All logic is on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result is available.
- `alu_ready`  out  1  ALU result is accepted on this edge.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ld_valid`  in  1  load result is available.
- `ld_ready`  out  1  load result is accepted on this edge.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load result.
- `issue_en`  in  1  an instruction with a destination register issues this cycle.
- `issue_rd`  in  5  destination register of the issuing instruction.
- `A3`  out  6  register file write address. Bit 5 is always 0.
- `WriteData`  out  32  register file write data.
- `WE`  out  1  register file write enable.
- `pending`  out  32  bit i = 1 means a write to x[i] is outstanding. Bit 0 is always 0.
- `rs1`, `rs2`  in  6 each  operand addresses for forwarding. Used only with `WB_BYPASS_EN`.
- `fwd1_hit`, `fwd2_hit`  out  1 each  the operand matches the write in flight.
- `fwd1_data`, `fwd2_data`  out  32 each  forwarded data.

## Operation
- Arbitration is combinational each cycle.
  - The load path has default priority.
  - The ALU path has priority when `starve_cnt == STARVE_MAX`.
  - `ld_ready = !Rst && (!alu_valid || starve_cnt != STARVE_MAX)`.
  - `alu_ready = !Rst && (!ld_valid || starve_cnt == STARVE_MAX)`.
  - Exactly one source is granted when both are valid.
- `starve_cnt` is a 2-bit counter (width is clog2(STARVE_MAX+1)).
  - Increments when `alu_valid && !alu_ready`.
  - Clears to 0 when the ALU is accepted or `alu_valid == 0`.
  - Saturates at `STARVE_MAX`.
- Accepted transfer (`valid && ready` at an edge):
  - `A3 <= {1'b0, rd}` and `WriteData <= data`.
  - `WE <= (rd != 0)`.
- With no transfer, `WE <= 0`, and `A3`/`WriteData` hold their values.
- A write with `rd == 0` is acknowledged normally but produces `WE = 0`. It does not touch `pending`.
- Scoreboard update, evaluated on every edge:
  - Set `pending[issue_rd]` when `issue_en && issue_rd != 0`.
  - Clear `pending[A3]` when `WE == 1`, i.e. on the edge on which the register file commits.
  - If the set and the clear target the same index on the same edge, the set wins (a newer producer is outstanding).
- Re-issue to an index that is already pending leaves it at 1. There is no counting, so the issue logic must not issue a second producer to the same rd while the first is outstanding.

## Timing
- Reset values:
  - `A3 = 0`, `WriteData = 0`, `WE = 0`, `pending = 0`, `starve_cnt = 0`.
  - `alu_ready = 0` and `ld_ready = 0` while `Rst` is high.
- Latency:
  - A transfer accepted at edge N drives `WE`/`A3`/`WriteData` during cycle N..N+1.
  - The register file commits at edge N+1, and `pending` clears at edge N+1.
- Throughput is one write per cycle. The output register always drains, so there is no back-pressure from the register file.
- `Rst` asserted mid-operation:
  - On the next edge all state clears, including any in-flight write (`WE` drops).
  - Producers must re-present their data after reset.
- Inputs with `valid == 0` are ignored regardless of the rd and data values.

## Configuration
- `WB_BYPASS_EN` defined:
  - `fwdK_hit = WE && (rsK == A3) && (rsK != 0)`.
  - `fwdK_data = fwdK_hit ? WriteData : 32'b0`.
  - Both are combinational from registered state, covering the cycle before the register file read reflects the write.
- `WB_BYPASS_EN` undefined:
  - `fwd1_hit`, `fwd2_hit`, `fwd1_data` and `fwd2_data` are tied to 0.
  - `rs1` and `rs2` are unused.
  - The ports remain present.

## Test plan
- **Reset then single ALU write.** Stimulus: `Rst` 2 cycles; `alu_valid=1`, `alu_rd=5`, `alu_data=32'hDEADBEEF` for one cycle. Required: `alu_ready=1`; next cycle `WE=1`, `A3=6'd5`, `WriteData=32'hDEADBEEF`; the cycle after, `WE=0`.
- **x0 suppression.** Stimulus: `issue_en`, `issue_rd=0`; then `ld_valid`, `ld_rd=0`, `ld_data=32'h1234`. Required: `ld_ready=1`; `WE` stays 0; `pending == 0`.
- **Arbitration and anti-starvation.** Stimulus: both sources valid continuously, distinct rd. Required: grants go L, L, L, then A (after 3 losses `starve_cnt=3`), then L, L, L, A, and so on.
- **Scoreboard.** Stimulus: issue rd=7; later write rd=7. Required: `pending[7]=1` from the issue edge until the `WE` edge. A second case issues rd=9 on the same edge that the write of rd=9 commits; `pending[9]` must remain 1.
- **Bypass** (`WB_BYPASS_EN`). Stimulus: `WE=1`, `A3=12`, `WriteData=32'hA5A5A5A5`, with `rs1=12` and `rs2=0`. Required: `fwd1_hit=1` with data `32'hA5A5A5A5`; `fwd2_hit=0`. Without the macro, all forwarding outputs are 0.
- **Reset mid-write.** Stimulus: accept a load with rd=3, then assert `Rst` on the next edge. Required: `WE=0`, `pending=0`, and both ready signals low while `Rst` is high.

Source files
------------

// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl: register file writeback arbiter with pending-destination scoreboard; WB_BYPASS_EN enables forwarding.
module wb_write_ctrl #(
  parameter int STARVE_MAX = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  output logic [5:0]  A3,
  output logic [31:0] WriteData,
  output logic        WE,
  output logic [31:0] pending,
  input  logic [5:0]  rs1,
  input  logic [5:0]  rs2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0] starve_cnt;
  logic          alu_prio, alu_go, ld_go;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data, pending_nxt;
  assign alu_prio  = starve_cnt == SMAX;
  assign ld_ready  = !Rst && (!alu_valid || !alu_prio);
  assign alu_ready = !Rst && (!ld_valid || alu_prio);
  assign ld_go     = ld_valid && ld_ready;
  assign alu_go    = alu_valid && alu_ready;
  assign sel_rd    = ld_go ? ld_rd : alu_rd;
  assign sel_data  = ld_go ? ld_data : alu_data;
  // Set after clear so a newer producer issued on the commit edge stays pending.
  always_comb begin
    pending_nxt = pending;
    if (WE) pending_nxt[A3[4:0]] = 1'b0;
    if (issue_en && issue_rd != 5'd0) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      A3         <= '0;
      WriteData  <= '0;
      WE         <= 1'b0;
      pending    <= '0;
      starve_cnt <= '0;
    end else begin
      WE      <= (ld_go || alu_go) && sel_rd != 5'd0;
      pending <= pending_nxt;
      if (ld_go || alu_go) begin
        A3        <= {1'b0, sel_rd};
        WriteData <= sel_data;
      end
      if (alu_go || !alu_valid) starve_cnt <= '0;
      else if (!alu_prio) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`ifdef WB_BYPASS_EN
  assign fwd1_hit  = WE && rs1 == A3 && rs1 != 6'd0;
  assign fwd2_hit  = WE && rs2 == A3 && rs2 != 6'd0;
  assign fwd1_data = fwd1_hit ? WriteData : 32'b0;
  assign fwd2_data = fwd2_hit ? WriteData : 32'b0;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = 32'b0;
  assign fwd2_data = 32'b0;
`endif
endmodule

// File: tb/tb_wb_write_ctrl.sv
// tb_wb_write_ctrl: directed self-checking bench for wb_write_ctrl.
module tb_wb_write_ctrl;
  logic        Clk = 1'b0;
  logic        Rst, alu_valid, ld_valid, issue_en;
  logic        alu_ready, ld_ready, WE, fwd1_hit, fwd2_hit;
  logic [4:0]  alu_rd, ld_rd, issue_rd;
  logic [31:0] alu_data, ld_data, WriteData, pending, fwd1_data, fwd2_data;
  logic [5:0]  A3, rs1, rs2;
  int checks = 0;
  int errors = 0;
`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  wb_write_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .A3(A3), .WriteData(WriteData), .WE(WE), .pending(pending),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    string pat = "LLLALLLA";
    Rst = 1; alu_valid = 1; ld_valid = 1; issue_en = 0;
    alu_rd = 5'd1; ld_rd = 5'd2; issue_rd = 0; alu_data = 32'h11; ld_data = 32'h22;
    rs1 = 0; rs2 = 0;
    step(); step();
    check("rst_we", WE, 0);
    check("rst_a3", A3, 0);
    check("rst_wd", WriteData, 0);
    check("rst_pend", pending, 0);
    check("rst_alu_rdy", alu_ready, 0);
    check("rst_ld_rdy", ld_ready, 0);
    Rst = 0; ld_valid = 0;
    alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("alu_rdy", alu_ready, 1);
    step(); alu_valid = 0;
    check("alu_we", WE, 1);
    check("alu_a3", A3, 5);
    check("alu_wd", WriteData, 32'hDEADBEEF);
    step();
    check("alu_we_drop", WE, 0);
    check("alu_a3_hold", A3, 5);
    issue_en = 1; issue_rd = 0;
    step(); issue_en = 0;
    check("x0_issue_pend", pending, 0);
    ld_valid = 1; ld_rd = 0; ld_data = 32'h1234;
    #1 check("x0_ld_rdy", ld_ready, 1);
    step(); ld_valid = 0;
    check("x0_we", WE, 0);
    check("x0_wd", WriteData, 32'h1234);
    check("x0_pend", pending, 0);
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA0;
    ld_valid = 1; ld_rd = 5'd11; ld_data = 32'hB0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("arb%0d_ld_rdy", i), ld_ready, pat[i] == "L");
      check($sformatf("arb%0d_alu_rdy", i), alu_ready, pat[i] == "A");
      step();
      check($sformatf("arb%0d_a3", i), A3, pat[i] == "L" ? 11 : 10);
      check($sformatf("arb%0d_we", i), WE, 1);
    end
    alu_valid = 0; ld_valid = 0;
    step();
    issue_en = 1; issue_rd = 5'd7;
    step(); issue_en = 0;
    check("sb_set7", pending, 32'h80);
    step();
    check("sb_hold7", pending, 32'h80);
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    step(); alu_valid = 0;
    check("sb_we7", WE, 1);
    check("sb_still7", pending, 32'h80);
    step();
    check("sb_clr7", pending, 0);
    issue_en = 1; issue_rd = 5'd9;
    step(); issue_en = 0;
    ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99;
    step(); ld_valid = 0;
    check("sb_we9", WE, 1);
    issue_en = 1; issue_rd = 5'd9;
    step(); issue_en = 0;
    check("sb_race9", pending, 32'h200);
    ld_valid = 1; ld_rd = 5'd12; ld_data = 32'hA5A5A5A5;
    step(); ld_valid = 0;
    rs1 = 6'd12; rs2 = 6'd0;
    #1;
    check("fwd1_hit", fwd1_hit, BYP);
    check("fwd1_data", fwd1_data, BYP ? 32'hA5A5A5A5 : 32'h0);
    check("fwd2_hit", fwd2_hit, 0);
    check("fwd2_data", fwd2_data, 0);
    rs1 = 6'd13;
    #1 check("fwd1_miss", fwd1_hit, 0);
    step();
    rs1 = 6'd12;
    #1 check("fwd1_no_we", fwd1_hit, 0);
    issue_en = 1; issue_rd = 5'd3;
    step(); issue_en = 0;
    ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h33;
    step();
    check("mid_we", WE, 1);
    Rst = 1; alu_valid = 1;
    #1;
    check("mid_ld_rdy", ld_ready, 0);
    check("mid_alu_rdy", alu_ready, 0);
    step();
    check("mid_we_drop", WE, 0);
    check("mid_pend", pending, 0);
    check("mid_a3", A3, 0);
    Rst = 0; alu_valid = 0; ld_valid = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
